// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the
// fetch / load-store memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int LS_MAX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   function automatic int streak_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant decision, load/store first unless
// fetch has been starved for LS_MAX grants in a row.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int LS_MAX = LS_MAX_DEF,
   parameter int SW     = streak_w(LS_MAX_DEF)
) (
   input  logic          if_req,
   input  logic          ls_req,
   input  logic [SW-1:0] streak,
   output logic          gnt_if,
   output logic          gnt_ls
);

   localparam logic [SW-1:0] STREAK_MAX = SW'(LS_MAX);

   // ls wins unless fetch is waiting and the streak is used up
   always_comb begin
      gnt_ls = ls_req && (!if_req || (streak < STREAK_MAX));
      gnt_if = if_req && !gnt_ls;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding arbiter sharing a single
// memory port between instruction fetch and load/store.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LS_MAX = LS_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_wr_en,
   input  logic [3:0]        ls_mask,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_ack,
   output logic [31:0]       ls_rdata,
   output logic              mem_req,
   output logic              mem_wr_en,
   output logic [3:0]        mem_mask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int SW = streak_w(LS_MAX);
   localparam logic [SW-1:0] STREAK_MAX = SW'(LS_MAX);

   state_t        state;
   state_t        state_nx;
   owner_t        owner;
   logic [SW-1:0] streak;
   logic          gnt_if;
   logic          gnt_ls;

   mem_arb_pick #(
      .LS_MAX (LS_MAX),
      .SW     (SW)
   ) u_pick (
      .if_req (if_req),
      .ls_req (ls_req),
      .streak (streak),
      .gnt_if (gnt_if),
      .gnt_ls (gnt_ls)
   );

   // next state: grant in IDLE, wait for memory, one ack cycle
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (gnt_ls || gnt_if) state_nx = ISSUE;
         ISSUE:   if (mem_ack) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // latch the winning request and track the ls streak
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_IF;
         streak    <= '0;
         mem_addr  <= '0;
         mem_mask  <= '0;
         mem_wr_en <= 1'b0;
         mem_wdata <= '0;
      end else if (state == IDLE) begin
         if (gnt_ls) begin
            owner     <= OWN_LS;
            mem_addr  <= ls_addr;
            mem_mask  <= ls_mask;
            mem_wr_en <= ls_wr_en;
            mem_wdata <= ls_wdata;
            if (!if_req)
               streak <= '0;
            else if (streak != STREAK_MAX)
               streak <= streak + SW'(1);
         end else if (gnt_if) begin
            owner     <= OWN_IF;
            mem_addr  <= if_addr;
            mem_mask  <= 4'b1111;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            streak    <= '0;
         end
      end
   end

   // capture read data into the owner's register
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata <= '0;
         ls_rdata <= '0;
      end else if (state == ISSUE && mem_ack && !mem_wr_en) begin
         if (owner == OWN_IF) if_rdata <= mem_rdata;
         else                 ls_rdata <= mem_rdata;
      end
   end

   // handshake outputs decoded from state and owner
   always_comb begin
      mem_req = (state == ISSUE);
      if_ack  = (state == RESP) && (owner == OWN_IF);
      ls_ack  = (state == RESP) && (owner == OWN_LS);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with
// a hand-driven memory responder.
module tb_mem_arbiter;

   localparam int AW = 7;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [31:0]   if_rdata;
   logic          ls_req;
   logic          ls_wr_en;
   logic [3:0]    ls_mask;
   logic [AW-1:0] ls_addr;
   logic [31:0]   ls_wdata;
   logic          ls_ack;
   logic [31:0]   ls_rdata;
   logic          mem_req;
   logic          mem_wr_en;
   logic [3:0]    mem_mask;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   int n_vec = 0;
   int n_bad = 0;

   mem_arbiter #(
      .ADDR_W (AW),
      .LS_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_wr_en  (ls_wr_en),
      .ls_mask   (ls_mask),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_ack    (ls_ack),
      .ls_rdata  (ls_rdata),
      .mem_req   (mem_req),
      .mem_wr_en (mem_wr_en),
      .mem_mask  (mem_mask),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // wait for mem_req, check fields, hold lat cycles, then ack
   task automatic serve(
      input string         tag,
      input int            lat,
      input logic [31:0]   rd,
      input logic [AW-1:0] ea,
      input logic [3:0]    em,
      input logic          ew,
      input logic [31:0]   ed,
      input int            ewait
   );
      int   w;
      logic bad;
      w   = 0;
      bad = 1'b0;
      while (!mem_req && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!mem_req) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_lat"}, 32'(w), 32'(ewait));
      check({tag, "_addr"}, 32'(mem_addr), 32'(ea));
      check({tag, "_mask"}, 32'(mem_mask), 32'(em));
      check({tag, "_wr"}, 32'(mem_wr_en), 32'(ew));
      check({tag, "_wdata"}, mem_wdata, ed);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (!mem_req || mem_addr !== ea ||
             mem_mask !== em || mem_wr_en !== ew ||
             mem_wdata !== ed)
            bad = 1'b1;
      end
      check({tag, "_hold"}, 32'(bad), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   // count ack pulses over four cycles, dropping req on ack
   task automatic collect(
      input string tag,
      input int    eif,
      input int    els
   );
      int nif;
      int nls;
      nif = 0;
      nls = 0;
      for (int i = 0; i < 4; i++) begin
         if (if_ack) begin
            nif++;
            if_req = 1'b0;
         end
         if (ls_ack) begin
            nls++;
            ls_req = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_if_acks"}, 32'(nif), 32'(eif));
      check({tag, "_ls_acks"}, 32'(nls), 32'(els));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck want finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      ls_req    = 1'b0;
      ls_wr_en  = 1'b0;
      ls_mask   = 4'h0;
      ls_addr   = '0;
      ls_wdata  = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_mask", 32'(mem_mask), 32'd0);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_ls_ack", 32'(ls_ack), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_ls_rdata", ls_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // fetch alone
      if_req  = 1'b1;
      if_addr = 7'h05;
      serve("fetch", 0, 32'h00500093, 7'h05,
            4'hF, 1'b0, 32'h0, 1);
      check("fetch_ack_now", 32'(if_ack), 32'd1);
      collect("fetch", 1, 0);
      check("fetch_rdata", if_rdata, 32'h00500093);

      // load
      ls_req   = 1'b1;
      ls_wr_en = 1'b0;
      ls_mask  = 4'hF;
      ls_addr  = 7'h22;
      ls_wdata = 32'h0BADF00D;
      serve("load", 1, 32'hCAFEF00D, 7'h22,
            4'hF, 1'b0, 32'h0BADF00D, 1);
      collect("load", 0, 1);
      check("load_rdata", ls_rdata, 32'hCAFEF00D);

      // store
      ls_req   = 1'b1;
      ls_wr_en = 1'b1;
      ls_mask  = 4'b0011;
      ls_addr  = 7'h10;
      ls_wdata = 32'hDEADBEEF;
      serve("store", 0, 32'h12345678, 7'h10,
            4'b0011, 1'b1, 32'hDEADBEEF, 1);
      collect("store", 0, 1);
      check("store_rdata", ls_rdata, 32'hCAFEF00D);

      // stray mem_ack while idle
      mem_ack   = 1'b1;
      mem_rdata = 32'h77777777;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check("stray_mem_req", 32'(mem_req), 32'd0);
      collect("stray", 0, 0);
      check("stray_if_rdata", if_rdata, 32'h00500093);
      if_req  = 1'b1;
      if_addr = 7'h40;
      serve("post_stray", 2, 32'h11112222, 7'h40,
            4'hF, 1'b0, 32'h0, 1);
      collect("post_stray", 1, 0);
      check("post_stray_rdata", if_rdata, 32'h11112222);

      // slow memory store at top address
      ls_req   = 1'b1;
      ls_wr_en = 1'b1;
      ls_mask  = 4'b1000;
      ls_addr  = 7'h7F;
      ls_wdata = 32'hA5A5A5A5;
      serve("slow", 5, 32'h0, 7'h7F,
            4'b1000, 1'b1, 32'hA5A5A5A5, 1);
      collect("slow", 0, 1);
      check("slow_rdata", ls_rdata, 32'hCAFEF00D);

      // contention: LS x4, IF, LS
      if_req   = 1'b1;
      if_addr  = 7'h04;
      ls_req   = 1'b1;
      ls_wr_en = 1'b0;
      ls_mask  = 4'hF;
      ls_addr  = 7'h03;
      ls_wdata = 32'h0;
      for (int k = 0; k < 6; k++) begin
         int   w;
         logic eif;
         eif = (k == 4);
         w   = 0;
         while (!mem_req && w < 20) begin
            @(negedge clk);
            w++;
         end
         check($sformatf("cont%0d_addr", k), 32'(mem_addr),
               eif ? 32'h4 : 32'h3);
         mem_ack   = 1'b1;
         mem_rdata = 32'(k);
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
         check($sformatf("cont%0d_if_ack", k),
               32'(if_ack), 32'(eif));
         check($sformatf("cont%0d_ls_ack", k),
               32'(ls_ack), 32'(!eif));
         if (k == 5) begin
            if_req = 1'b0;
            ls_req = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      check("cont_if_rdata", if_rdata, 32'h4);
      check("cont_ls_rdata", ls_rdata, 32'h5);

      // reset during ISSUE abandons the load
      ls_req   = 1'b1;
      ls_wr_en = 1'b0;
      ls_addr  = 7'h11;
      begin
         int w;
         w = 0;
         while (!mem_req && w < 20) begin
            @(negedge clk);
            w++;
         end
      end
      check("mid_mem_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_mem_req", 32'(mem_req), 32'd0);
      check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_mem_mask", 32'(mem_mask), 32'd0);
      check("mid_rst_if_rdata", if_rdata, 32'd0);
      check("mid_rst_ls_rdata", ls_rdata, 32'd0);
      rst    = 1'b0;
      ls_req = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      collect("mid_rst", 0, 0);
      check("mid_rst_req_after", 32'(mem_req), 32'd0);
      check("mid_rst_ls_after", ls_rdata, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
